yuv422_to_rgb: RTL
==================

Name: yuv422_to_rgb

Overview:
- Inverse of the CSI bridge colour converter. Takes 4-pixel-per-clock packed YUV422 (64-bit beats, 8 bits per sample) and produces 4-pixel RGB888 (96-bit beats).
- Used on the playback/test-pattern path that feeds YUV422 frames back into RGB processing and display.
- Fully pipelined, one beat per clock, with a valid/ready stall handshake on both sides.

Parameters:
- PIXEL_PER_CLK, 4, pixels per beat; must be even; pixel pairs share U/V.
- COEF_FRAC, 8, fractional bits of the fixed-point coefficients.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- yuv_i  in  PIXEL_PER_CLK*16  packed beat, MSB first: {Y0,U0,Y1,V0, Y2,U2,Y3,V2}, 8 bits each.
- yuv_valid_i  in  1  yuv_i holds a beat.
- yuv_ready_o  out  1  the block accepts a beat this cycle.
- rgb_o  out  PIXEL_PER_CLK*24  {R0,G0,B0, R1,G1,B1, R2,G2,B2, R3,G3,B3}, MSB first, 8 bits per channel.
- rgb_valid_o  out  1  rgb_o holds a converted beat.
- rgb_ready_i  in  1  downstream accepts rgb_o this cycle.

Behaviour:
- Reset (asynchronous): all pipeline data registers, stage-valid flags, rgb_o and rgb_valid_o clear to 0.
- Pipeline enable: en = !rgb_valid_o || rgb_ready_i.
  - yuv_ready_o = en (combinational).
  - A beat transfers in when yuv_valid_i && en.
  - When en = 0, every stage holds its data and valid flag. No beat is dropped or duplicated.
- Pipeline stages. A beat accepted at edge N is on rgb_o with rgb_valid_o=1 after edge N+3, given en stays high.
  - S1: register the samples. Chroma offsets U'=U-128, V'=V-128 as signed 9-bit. Luma Y as unsigned, zero-extended.
  - S2: signed products, once per pixel pair:
    - rv = 359*V'
    - gu = 88*U'
    - gv = 183*V'
    - bu = 454*U'
  - S3: per pixel, using its pair's chroma terms:
    - R = Y + ((rv + 128) >>> 8)
    - G = Y + ((-gu - gv + 128) >>> 8)
    - B = Y + ((bu + 128) >>> 8)
    - Intermediates are signed, at least 20 bits; >>> is an arithmetic (floor) shift.
  - S4: clamp each channel to 0..255 and register into rgb_o. No wrap-around is permitted.
- Pixel pairs: pixels 0 and 1 use U0/V0; pixels 2 and 3 use U2/V2.
- Bubbles: stage valid flags advance with en, so gaps in the input appear as gaps on the output. rgb_valid_o deasserts only when the output is consumed and no valid beat follows.
- Simultaneous events: input accept and output consume in the same cycle is the steady state at full throughput.
- Reset mid-operation flushes all in-flight beats. The first beat after reset release is accepted in the same cycle it is offered, provided rgb_valid_o=0.
- rgb_o holds its value whenever rgb_valid_o=1 && rgb_ready_i=0.

Optional Feature:
- Macro: YUV_LIMITED_RANGE_EN.
- Defined: input is treated as BT.601 limited range. C = Y-16 (signed).
  - R = (298C + 409V' + 128) >>> 8
  - G = (298C - 100U' - 208V' + 128) >>> 8
  - B = (298C + 516U' + 128) >>> 8
  - Same clamp and the same latency.
- Undefined: full-swing equations as above.

Decomposition:
- Package yuv_rgb_pkg holds:
  - sample width (8) and coefficient constants for both ranges
  - intermediate width (20)
  - COEF_FRAC rounding constant (128)
  - a clamp function
- Sub-module yuv_pair_to_rgb: converts two lumas plus one shared U/V through S1–S4 under a shared en. It is instantiated PIXEL_PER_CLK/2 times.
- The top level owns the handshake and the valid pipeline.

Test Plan:
- Grey: all Y=128, U=V=128, ready held high → every channel 128; rgb_valid_o rises 3 edges after accept.
- Clamp high: Y=255, U=128, V=255 → R=255 (clamped), G=164, B=255.
- Clamp low: Y=0, U=128, V=0 → R=0, G=92, B=0. Also Y=100, U=200, V=128 → R=100, G=75, B=228.
- Backpressure: stream 8 distinct beats with rgb_ready_i toggling randomly →
  - output order and values match the model;
  - rgb_o is stable while stalled;
  - yuv_ready_o = !rgb_valid_o || rgb_ready_i every cycle.
- Reset mid-stream: assert reset_i asynchronously with 3 beats in flight → rgb_valid_o=0 immediately. After release, a new beat appears 3 edges after accept with no stale data.
- With YUV_LIMITED_RANGE_EN: Y=16, U=V=128 → 0,0,0. Y=235, U=V=128 → 255,255,255.

Source files
------------

// File: rtl/yuv_rgb_pkg.sv
// yuv_rgb_pkg: shared widths, Q8 colour coefficients for both ranges and the output clamp.
package yuv_rgb_pkg;
  localparam int SAMPLE_W = 8;
  localparam int INTER_W = 20;
  localparam int FRAC_DEF = 8;
  localparam int ROUND_C = 128;
  localparam int FULL_Y = 256;
  localparam int FULL_YOFF = 0;
  localparam int FULL_RV = 359;
  localparam int FULL_GU = 88;
  localparam int FULL_GV = 183;
  localparam int FULL_BU = 454;
  localparam int LIM_Y = 298;
  localparam int LIM_YOFF = 16;
  localparam int LIM_RV = 409;
  localparam int LIM_GU = 100;
  localparam int LIM_GV = 208;
  localparam int LIM_BU = 516;
  typedef logic signed [INTER_W-1:0] inter_t;
  function automatic logic [SAMPLE_W-1:0] clamp8(input inter_t v);
    return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/yuv422_to_rgb_if.sv
// yuv422_to_rgb_if: YUV422 input stream and RGB888 output stream with valid/ready handshakes.
interface yuv422_to_rgb_if #(parameter int PIXEL_PER_CLK = 4);
  logic [PIXEL_PER_CLK*16-1:0] yuv_i;
  logic yuv_valid_i;
  logic yuv_ready_o;
  logic [PIXEL_PER_CLK*24-1:0] rgb_o;
  logic rgb_valid_o;
  logic rgb_ready_i;
  modport master(output yuv_i, yuv_valid_i, rgb_ready_i, input yuv_ready_o, rgb_o, rgb_valid_o);
  modport slave(input yuv_i, yuv_valid_i, rgb_ready_i, output yuv_ready_o, rgb_o, rgb_valid_o);
endinterface

// File: rtl/yuv_pair_to_rgb.sv
// yuv_pair_to_rgb: four-stage conversion of two lumas sharing one U/V sample.
// YUV_LIMITED_RANGE_EN selects BT.601 limited-range coefficients instead of full swing.
module yuv_pair_to_rgb import yuv_rgb_pkg::*; #(
  parameter int COEF_FRAC = FRAC_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [SAMPLE_W-1:0]   ya_i,
  input  logic [SAMPLE_W-1:0]   yb_i,
  input  logic [SAMPLE_W-1:0]   u_i,
  input  logic [SAMPLE_W-1:0]   v_i,
  output logic [6*SAMPLE_W-1:0] rgb_o
);
`ifdef YUV_LIMITED_RANGE_EN
  localparam int C_Y = LIM_Y, Y_OFF = LIM_YOFF, C_RV = LIM_RV, C_GU = LIM_GU, C_GV = LIM_GV, C_BU = LIM_BU;
`else
  localparam int C_Y = FULL_Y, Y_OFF = FULL_YOFF, C_RV = FULL_RV, C_GU = FULL_GU, C_GV = FULL_GV, C_BU = FULL_BU;
`endif
  localparam inter_t RND = inter_t'(ROUND_C);
  logic signed [SAMPLE_W:0] u_q, v_q;
  inter_t rv_q, gu_q, gv_q, bu_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      u_q <= '0;
      v_q <= '0;
      rv_q <= '0;
      gu_q <= '0;
      gv_q <= '0;
      bu_q <= '0;
    end else if (en_i) begin
      u_q <= $signed({1'b0, u_i}) - 9'sd128;
      v_q <= $signed({1'b0, v_i}) - 9'sd128;
      rv_q <= inter_t'(v_q) * inter_t'(C_RV);
      gu_q <= inter_t'(u_q) * inter_t'(C_GU);
      gv_q <= inter_t'(v_q) * inter_t'(C_GV);
      bu_q <= inter_t'(u_q) * inter_t'(C_BU);
    end
  for (genvar p = 0; p < 2; p++) begin : g_pix
    logic [SAMPLE_W-1:0] y_q;
    inter_t l_q, r_q, g_q, b_q;
    logic [3*SAMPLE_W-1:0] rgb_q;
    // luma is pre-scaled by its coefficient so S3 is a single rounded shift per channel
    always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
        y_q <= '0;
        l_q <= '0;
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
        rgb_q <= '0;
      end else if (en_i) begin
        y_q <= (p == 0) ? ya_i : yb_i;
        l_q <= (inter_t'({1'b0, y_q}) - inter_t'(Y_OFF)) * inter_t'(C_Y);
        r_q <= (l_q + rv_q + RND) >>> COEF_FRAC;
        g_q <= (l_q - gu_q - gv_q + RND) >>> COEF_FRAC;
        b_q <= (l_q + bu_q + RND) >>> COEF_FRAC;
        rgb_q <= {clamp8(r_q), clamp8(g_q), clamp8(b_q)};
      end
  end
  assign rgb_o = {g_pix[0].rgb_q, g_pix[1].rgb_q};
endmodule

// File: rtl/yuv422_to_rgb.sv
// yuv422_to_rgb: 4-stage pipelined YUV422 to RGB888 converter with valid/ready stalls.
// YUV_LIMITED_RANGE_EN switches the pair converters to BT.601 limited range.
module yuv422_to_rgb import yuv_rgb_pkg::*; #(
  parameter int PIXEL_PER_CLK = 4,
  parameter int COEF_FRAC = FRAC_DEF
) (
  input logic clk_i,
  input logic reset_i,
  yuv422_to_rgb_if.slave bus
);
  localparam int YW = PIXEL_PER_CLK * 16;
  localparam int RW = PIXEL_PER_CLK * 24;
  logic [3:0] vld_q, vld_d;
  logic en;
  logic [RW-1:0] rgb;
  assign en = !vld_q[3] || bus.rgb_ready_i;
  assign bus.yuv_ready_o = en;
  assign bus.rgb_valid_o = vld_q[3];
  assign bus.rgb_o = rgb;
  always_comb vld_d = en ? {vld_q[2:0], bus.yuv_valid_i} : vld_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) vld_q <= '0;
    else vld_q <= vld_d;
  for (genvar k = 0; k < PIXEL_PER_CLK / 2; k++) begin : g_pair
    yuv_pair_to_rgb #(.COEF_FRAC(COEF_FRAC)) u_pair (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (en),
      .ya_i   (bus.yuv_i[YW-1-32*k -: 8]),
      .u_i    (bus.yuv_i[YW-9-32*k -: 8]),
      .yb_i   (bus.yuv_i[YW-17-32*k -: 8]),
      .v_i    (bus.yuv_i[YW-25-32*k -: 8]),
      .rgb_o  (rgb[RW-1-48*k -: 48])
    );
  end
endmodule
